// File: rtl/clz_log.sv
// Constant-time count-leading-zeros and left-normalizer, one binary-search round per cycle.
// Optional `zero` output flag is enabled by defining CLZ_ZERO_FLAG_EN.
module clz_log #(
    parameter  int unsigned LOGSIZE = 8,
    localparam int unsigned SIZE    = 1 << LOGSIZE
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [SIZE-1:0]    in_i,
    output logic [LOGSIZE-1:0] count_o,
    output logic [SIZE-1:0]    norm_o,
`ifdef CLZ_ZERO_FLAG_EN
    output logic               zero_o,
`endif
    output logic               done_o
);

    localparam int unsigned IDXW = (LOGSIZE > 1) ? $clog2(LOGSIZE) : 1;
    localparam logic [LOGSIZE-1:0] ROUND_FIRST = LOGSIZE'(1) << (LOGSIZE - 1);

    logic [SIZE-1:0]    value_q,   value_d;
    logic [LOGSIZE-1:0] cnt_q,     cnt_d;
    logic [LOGSIZE-1:0] counter_q, counter_d;
    logic               done_q,    done_d;
    logic               zero_q,    zero_d;

    // Mask selecting the top (1<<i) bits of the operand.
    function automatic logic [SIZE-1:0] top_mask(input int unsigned i);
        top_mask = ~({SIZE{1'b1}} >> (32'd1 << i));
    endfunction

    // Next-state: restart on done, otherwise run the round selected by the one-hot counter.
    always_comb begin
        value_d   = value_q;
        cnt_d     = cnt_q;
        counter_d = counter_q >> 1;
        done_d    = counter_q[0];
        zero_d    = zero_q;
        if (done_q) begin
            value_d   = in_i;
            cnt_d     = '0;
            counter_d = ROUND_FIRST;
            done_d    = 1'b0;
            zero_d    = 1'b0;
        end else begin
            for (int unsigned i = 0; i < LOGSIZE; i++) begin
                if (counter_q[IDXW'(i)] && ((value_q & top_mask(i)) == '0)) begin
                    value_d = value_q << (32'd1 << i);
                    cnt_d   = cnt_q | counter_q;
                end
            end
            if (counter_q[0]) begin
                zero_d = (value_d == '0);
            end
        end
    end

    // Reset behaves as a start edge that also suppresses done.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            value_q   <= in_i;
            cnt_q     <= '0;
            counter_q <= ROUND_FIRST;
            done_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            value_q   <= value_d;
            cnt_q     <= cnt_d;
            counter_q <= counter_d;
            done_q    <= done_d;
            zero_q    <= zero_d;
        end
    end

    assign count_o = cnt_q;
    assign norm_o  = value_q;
    assign done_o  = done_q;
`ifdef CLZ_ZERO_FLAG_EN
    assign zero_o  = zero_q;
`endif

endmodule

// File: tb/tb_clz_log.sv
// Scoreboard bench for clz_log at LOGSIZE=4: driver pushes reference results, monitor checks on done.
module tb_clz_log;

    localparam int unsigned LOGSIZE = 4;
    localparam int unsigned SIZE    = 16;

    typedef struct {
        logic [15:0] op;
        logic [3:0]  count;
        logic [15:0] norm;
        logic        zero;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [SIZE-1:0]   in_v = 16'h0001;
    logic [LOGSIZE-1:0] count;
    logic [SIZE-1:0]   norm;
    logic              done;
    logic              zero;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    clz_log #(.LOGSIZE(LOGSIZE)) dut (
        .clock_i (clk),
        .reset_i (reset),
        .in_i    (in_v),
        .count_o (count),
        .norm_o  (norm),
`ifdef CLZ_ZERO_FLAG_EN
        .zero_o  (zero),
`endif
        .done_o  (done)
    );

`ifndef CLZ_ZERO_FLAG_EN
    assign zero = 1'b0;
`endif

    // Reference: scan from the MSB for the first one; zero operand counts as all ones.
    function automatic exp_t model(input logic [15:0] x);
        exp_t e;
        int   c;
        e.op = x;
        if (x == 16'h0000) begin
            e.count = 4'hF;
            e.norm  = 16'h0000;
            e.zero  = 1'b1;
        end else begin
            c = 0;
            while (x[15 - c] == 1'b0) c++;
            e.count = 4'(c);
            e.norm  = x << c;
            e.zero  = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Called at the negedge after a start edge that was a reset edge.
    task automatic check_reset_state(input logic [15:0] sampled);
        check("reset_done", 32'(done), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_norm", 32'(norm), 32'(sampled));
`ifdef CLZ_ZERO_FLAG_EN
        check("reset_zero", 32'(zero), 32'd0);
`endif
    endtask

    // Present x now (at a negedge just after a start edge); it is sampled on the next start edge.
    task automatic issue(input logic [15:0] x);
        in_v = x;
        repeat (5) @(posedge clk);
        sb.push_back(model(x));
        @(negedge clk);
    endtask

    // Monitor: done must appear exactly 4 checks after each start; compare against scoreboard.
    initial begin
        int   since;
        logic exp_done;
        exp_t e;
        since = 99;
        forever begin
            @(negedge clk);
            #1;
            exp_done = (since == 4);
            if ((done === 1'b1) != exp_done) begin
                n_vec++;
                n_bad++;
                $display("FAIL done_timing: done=%b required %b", done, exp_done);
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with empty scoreboard required none");
                end else begin
                    e = sb.pop_front();
                    check("count", 32'(count), 32'(e.count));
                    check("norm", 32'(norm), 32'(e.norm));
`ifdef CLZ_ZERO_FLAG_EN
                    check("zero", 32'(zero), 32'(e.zero));
`endif
                    if (e.op != 16'h0000) begin
                        check("norm_msb", 32'(norm[15]), 32'd1);
                        check("chain_unshift", 32'(norm >> count), 32'(e.op));
                    end
                end
            end
            if (reset === 1'b1 || done === 1'b1) since = 0;
            else if (since < 99) since++;
        end
    end

    initial begin
        logic [15:0] x;
        logic [15:0] dir[6] = '{16'h0001, 16'h8000, 16'h00F0, 16'h0300, 16'h0000, 16'h0001};

        repeat (2) @(posedge clk);
        sb.push_back(model(16'h0001));
        @(negedge clk);
        check_reset_state(16'h0001);
        reset = 1'b0;

        foreach (dir[i]) issue(dir[i]);

        for (int k = 0; k < 100; k++) begin
            x = 16'($urandom) >> $urandom_range(0, 16);
            issue(x);
        end

        // Abort a run two cycles in; the new operand is taken on the reset edge.
        issue(16'h0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        in_v  = 16'h0F00;
        void'(sb.pop_back());
        @(posedge clk);
        sb.push_back(model(16'h0F00));
        @(negedge clk);
        check_reset_state(16'h0F00);
        reset = 1'b0;

        issue(16'h00F0);
        issue(16'h8000);
        issue(16'h0001);

        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
